// File: rtl/icdir_ctl.sv
// Instruction-cache directory controller.
// Owns the single address port of a 128-line directory and arbitrates between
// a full-directory clear sweep, line fills from the miss path and tag lookups
// from fetch. A lookup's hit/miss result appears the cycle after it is
// accepted, using the read data the directory returns for that address.
module icdir_ctl #(
    parameter int LINES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lk_valid,
    output logic        lk_ready,
    input  logic [6:0]  lk_idx,
    input  logic [20:0] lk_tag,
    output logic        rsp_valid,
    output logic        rsp_hit,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [6:0]  fill_idx,
    input  logic [20:0] fill_tag,
    input  logic        inv_all,
    output logic        busy,
    output logic [6:0]  dir_rd_adr,
    input  logic [21:0] dir_rd_dat,
    output logic [3:0]  dir_wr_en,
    output logic [6:0]  dir_wr_adr,
    output logic [21:0] dir_wr_dat
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_SWEEP = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // Last index written by a sweep; the counter never wraps past it.
    localparam logic [6:0] LAST_IDX = 7'(LINES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  sweep_cnt_q;
    logic [6:0]  sweep_cnt_d;
    logic        pend_q;
    logic        pend_d;
    logic [20:0] tag_q;
    logic [20:0] tag_d;
    logic        lk_acc_s;

    // Port arbitration: sweep writes, then fills, then lookups.
    always_comb begin
        lk_ready   = 1'b0;
        fill_ready = 1'b0;
        dir_rd_adr = 7'd0;
        dir_wr_en  = 4'b0000;
        dir_wr_dat = 22'd0;
        busy       = 1'b1;
        case (state_q)
            ST_RST: begin
                busy = 1'b1;
            end
            ST_SWEEP: begin
                dir_rd_adr = sweep_cnt_q;
                dir_wr_en  = 4'b1111;
                dir_wr_dat = 22'd0;
                busy       = 1'b1;
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (inv_all) begin
                    // Clear request wins; the port stays quiet this cycle.
                    dir_rd_adr = 7'd0;
                end else if (fill_valid) begin
                    fill_ready = 1'b1;
                    dir_rd_adr = fill_idx;
                    dir_wr_en  = 4'b1111;
                    dir_wr_dat = {1'b1, fill_tag};
                end else begin
                    lk_ready   = 1'b1;
                    dir_rd_adr = lk_idx;
                end
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign dir_wr_adr = dir_rd_adr;
    assign lk_acc_s   = lk_valid & lk_ready;

    // Hit is judged against the data the directory returns for last cycle's address.
    always_comb begin
        rsp_valid = pend_q;
        rsp_hit   = pend_q & dir_rd_dat[21] & (dir_rd_dat[20:0] == tag_q);
    end

    // Next-state logic for the sequencer, sweep counter and pending lookup.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            ST_RST: begin
                state_d     = ST_SWEEP;
                sweep_cnt_d = 7'd0;
            end
            ST_SWEEP: begin
                if (inv_all) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = 7'd0;
                end else if (sweep_cnt_q == LAST_IDX) begin
                    state_d     = ST_IDLE;
                    sweep_cnt_d = 7'd0;
                end else begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = sweep_cnt_q + 7'd1;
                end
            end
            ST_IDLE: begin
                if (inv_all) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = 7'd0;
                end else begin
                    state_d     = ST_IDLE;
                    sweep_cnt_d = sweep_cnt_q;
                end
            end
            default: begin
                state_d     = ST_RST;
                sweep_cnt_d = 7'd0;
            end
        endcase

        if (lk_acc_s) begin
            pend_d = 1'b1;
            tag_d  = lk_tag;
        end else begin
            pend_d = 1'b0;
            tag_d  = tag_q;
        end
    end

    // State registers; reset also drops any lookup still awaiting its response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RST;
            sweep_cnt_q <= 7'd0;
            pend_q      <= 1'b0;
            tag_q       <= 21'd0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            pend_q      <= pend_d;
            tag_q       <= tag_d;
        end
    end

endmodule

// File: tb/tb_icdir_ctl.sv
// Testbench for icdir_ctl: directed scenarios followed by random traffic,
// with a behavioural directory RAM and a cycle-level reference model.
module tb_icdir_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lk_valid = 1'b0;
    logic        lk_ready;
    logic [6:0]  lk_idx = 7'd0;
    logic [20:0] lk_tag = 21'd0;
    logic        rsp_valid;
    logic        rsp_hit;
    logic        fill_valid = 1'b0;
    logic        fill_ready;
    logic [6:0]  fill_idx = 7'd0;
    logic [20:0] fill_tag = 21'd0;
    logic        inv_all = 1'b0;
    logic        busy;
    logic [6:0]  dir_rd_adr;
    logic [21:0] dir_rd_dat;
    logic [3:0]  dir_wr_en;
    logic [6:0]  dir_wr_adr;
    logic [21:0] dir_wr_dat;

    localparam logic [20:0] TAG_A = 21'h0ABCD;
    localparam logic [20:0] TAG_B = 21'h0ABCE;

    int n_checks = 0;
    int n_err    = 0;

    icdir_ctl #(.LINES(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .lk_valid   (lk_valid),
        .lk_ready   (lk_ready),
        .lk_idx     (lk_idx),
        .lk_tag     (lk_tag),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_idx   (fill_idx),
        .fill_tag   (fill_tag),
        .inv_all    (inv_all),
        .busy       (busy),
        .dir_rd_adr (dir_rd_adr),
        .dir_rd_dat (dir_rd_dat),
        .dir_wr_en  (dir_wr_en),
        .dir_wr_adr (dir_wr_adr),
        .dir_wr_dat (dir_wr_dat)
    );

    always #5 clk = ~clk;

    // Directory RAM: read data one cycle after the address, write at the edge.
    // Preloaded with valid TAG_A everywhere so a missing clear shows up as a hit.
    logic [21:0] mem [128];
    logic [21:0] rd_q = 22'd0;
    bit          ram_init = 1'b0;
    assign dir_rd_dat = rd_q;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= {1'b1, TAG_A};
            ram_init <= 1'b1;
        end else begin
            rd_q <= mem[dir_rd_adr];
            if (dir_wr_en == 4'b1111) mem[dir_wr_adr] <= dir_wr_dat;
        end
    end

    // Reference model: expected directory contents plus busy countdown.
    bit          ref_vld [128];
    logic [20:0] ref_tag [128];
    bit          m_rst     = 1'b1;
    int          busy_left = 0;
    bit          exp_pend  = 1'b0;
    bit          exp_hit   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 128; i++) ref_vld[i] = 1'b0;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model.
    task automatic tick();
        bit          idle;
        bit          chk_adr;
        bit          nxt_pend;
        bit          nxt_hit;
        logic [6:0]  e_adr;
        logic [3:0]  e_we;
        logic [21:0] e_wd;
        logic        e_lr;
        logic        e_fr;
        @(negedge clk);
        if (rst) begin
            m_rst    = 1'b1;
            exp_pend = 1'b0;
        end
        idle    = !rst && !m_rst && (busy_left == 0);
        chk_adr = 1'b1;
        e_lr = 1'b0; e_fr = 1'b0; e_adr = 7'd0; e_we = 4'b0000; e_wd = 22'd0;
        if (rst || m_rst) begin
            e_adr = 7'd0;
        end else if (!idle) begin
            e_adr = 7'(128 - busy_left);
            e_we  = 4'b1111;
        end else if (inv_all) begin
            chk_adr = 1'b0;
        end else if (fill_valid) begin
            e_fr  = 1'b1;
            e_adr = fill_idx;
            e_we  = 4'b1111;
            e_wd  = {1'b1, fill_tag};
        end else begin
            e_lr  = 1'b1;
            e_adr = lk_idx;
        end
        chk("busy", 32'(busy), 32'(!idle));
        chk("lk_ready", 32'(lk_ready), 32'(e_lr));
        chk("fill_ready", 32'(fill_ready), 32'(e_fr));
        chk("dir_wr_en", 32'(dir_wr_en), 32'(e_we));
        chk("dir_wr_dat", 32'(dir_wr_dat), 32'(e_wd));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_pend));
        chk("rsp_hit", 32'(rsp_hit), 32'(exp_pend & exp_hit));
        if (chk_adr) begin
            chk("dir_rd_adr", 32'(dir_rd_adr), 32'(e_adr));
            chk("dir_wr_adr", 32'(dir_wr_adr), 32'(e_adr));
        end

        nxt_pend = idle && !inv_all && !fill_valid && lk_valid;
        nxt_hit  = ref_vld[lk_idx] && (ref_tag[lk_idx] == lk_tag);
        if (idle && !inv_all && fill_valid) begin
            ref_vld[fill_idx] = 1'b1;
            ref_tag[fill_idx] = fill_tag;
        end
        if (rst) begin
            nxt_pend = 1'b0;
        end else if (m_rst) begin
            m_rst     = 1'b0;
            busy_left = 128;
            clear_ref();
        end else if (inv_all) begin
            busy_left = 128;
            clear_ref();
        end else if (busy_left > 0) begin
            busy_left--;
        end
        exp_pend = nxt_pend;
        exp_hit  = nxt_hit;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [6:0] idx, input logic [20:0] tag);
        lk_valid = 1'b1; lk_idx = idx; lk_tag = tag;
        tick();
        lk_valid = 1'b0;
    endtask

    initial begin
        clear_ref();
        #1 rst = 1'b1;
        repeat (3) tick();

        // Release with a lookup held across the whole sweep; it is served in cycle 129.
        rst = 1'b0;
        lk_valid = 1'b1; lk_idx = 7'd5; lk_tag = TAG_A;
        repeat (129) tick();
        tick();
        lk_valid = 1'b0;
        tick();

        // Fill then lookups: hit, wrong tag, neighbouring index.
        fill_valid = 1'b1; fill_idx = 7'h12; fill_tag = TAG_A;
        tick();
        fill_valid = 1'b0;
        lookup(7'h12, TAG_A);
        lookup(7'h12, TAG_B);
        lookup(7'h13, TAG_A);
        tick();

        // Fill and lookup in the same cycle: fill wins, lookup follows and hits.
        fill_valid = 1'b1; fill_idx = 7'h20; fill_tag = 21'h01234;
        lk_valid = 1'b1; lk_idx = 7'h20; lk_tag = 21'h01234;
        tick();
        fill_valid = 1'b0;
        tick();
        lk_valid = 1'b0;
        tick();

        // Back-to-back lookups alternating hit and miss.
        for (int k = 0; k < 4; k++) begin
            lk_valid = 1'b1; lk_idx = 7'h12; lk_tag = (k % 2 == 0) ? TAG_A : TAG_B;
            tick();
        end
        lk_valid = 1'b0;
        tick();

        // Clear right after a lookup, with a restart at sweep count 60.
        lookup(7'h12, TAG_A);
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        repeat (60) tick();
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        repeat (128) tick();
        lookup(7'h12, TAG_A);
        tick();

        // Reset asserted at sweep count 40, then the full sweep reruns.
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (130) tick();

        // Reset with a lookup response outstanding.
        fill_valid = 1'b1; fill_idx = 7'h03; fill_tag = TAG_A;
        tick();
        fill_valid = 1'b0;
        lookup(7'h03, TAG_A);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (130) tick();

        // Random mix of fills, lookups and occasional clears.
        for (int n = 0; n < 400; n++) begin
            lk_valid   = ($urandom_range(0, 3) != 0);
            lk_idx     = 7'($urandom_range(0, 7));
            lk_tag     = ($urandom_range(0, 1) == 0) ? TAG_A : TAG_B;
            fill_valid = ($urandom_range(0, 3) == 0);
            fill_idx   = 7'($urandom_range(0, 7));
            fill_tag   = ($urandom_range(0, 1) == 0) ? TAG_A : TAG_B;
            inv_all    = ($urandom_range(0, 99) == 0);
            tick();
        end
        lk_valid = 1'b0; fill_valid = 1'b0; inv_all = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/icdir_ctl.md
# icdir_ctl

Sequencing and arbitration controller for the 128-line instruction-cache directory. It owns the directory's single address port and serves three sources: directory clear (after reset or on `inv_all`), line fills from the miss path, and tag lookups from fetch. Clears have priority over fills, and fills over lookups. Hit/miss is resolved one cycle after a lookup is accepted. The block sits between the fetch/miss logic and the directory instance.

## Interface
- `LINES`, 128: directory depth; sweep length; max 128 (7-bit index).
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `lk_valid`  in  1  lookup request
- `lk_ready`  out  1  lookup accepted when `lk_valid & lk_ready`
- `lk_idx`  in  7  lookup line index
- `lk_tag`  in  21  lookup tag
- `rsp_valid`  out  1  lookup result valid
- `rsp_hit`  out  1  lookup hit; meaningful only when `rsp_valid`
- `fill_valid`  in  1  fill request (mark line valid with tag)
- `fill_ready`  out  1  fill accepted when `fill_valid & fill_ready`
- `fill_idx`  in  7  fill line index
- `fill_tag`  in  21  fill tag
- `inv_all`  in  1  single-cycle request to invalidate every line
- `busy`  out  1  reset-hold or sweep in progress
- `dir_rd_adr`  out  7  directory address
- `dir_rd_dat`  in  22  directory data, {valid, tag[20:0]}; valid the cycle after the address
- `dir_wr_en`  out  4  directory write enable, 4'b1111 on write, 4'b0000 otherwise
- `dir_wr_adr`  out  7  always equal to `dir_rd_adr`
- `dir_wr_dat`  out  22  write data; 22'b0 when not writing

## Operation
- States:
  - RST: entered asynchronously by `rst`.
  - SWEEP: clears the directory.
  - IDLE: serves fills and lookups.
- RST:
  - All outputs zero except `busy` = 1.
  - First edge with `rst` low goes to SWEEP with `sweep_cnt` = 0.
- SWEEP:
  - `dir_rd_adr` = `sweep_cnt`, `dir_wr_en` = 1111, `dir_wr_dat` = 0, `busy` = 1.
  - `lk_ready` = `fill_ready` = 0.
  - `sweep_cnt` is 7 bits and increments each cycle.
  - In the cycle `sweep_cnt` = LINES-1, go to IDLE next.
- IDLE, priority order:
  - `inv_all` = 1: no request is accepted this cycle, there is no write, and the next state is SWEEP with count 0.
  - Else `fill_valid`: `fill_ready` = 1, `dir_rd_adr` = `fill_idx`, `dir_wr_en` = 1111, `dir_wr_dat` = {1'b1, `fill_tag`}.
  - Else `lk_ready` = 1 and `dir_rd_adr` = `lk_idx`. On accept, `lk_tag` is registered into `tag_q` and `pend` is set.
  - `lk_ready` and `fill_ready` are combinational from state, `fill_valid` and `inv_all`. Requesters may hold requests across stall cycles.
- `inv_all` during SWEEP restarts the sweep at count 0 on the next cycle.
- Response:
  - `rsp_valid` = `pend`; `pend` clears unless a new lookup is accepted that cycle.
  - `rsp_hit` = `pend` & `dir_rd_dat[21]` & (`dir_rd_dat[20:0]` == `tag_q`).
  - Responses are in order, one per accepted lookup, at up to one per cycle.
- A response is never dropped. A lookup accepted in cycle N responds in N+1 even if N+1 is a fill, SWEEP, or `inv_all` cycle. It returns the directory contents as of cycle N.
- No forwarding: a fill in cycle N followed by a lookup to the same index in N+1 sees the filled entry, because the write commits at the end of N.
- `rst` asserted mid-sweep or mid-lookup:
  - `pend` clears immediately and no response is issued.
  - The full sweep reruns after release.

## Timing
- Reset release sequence:
  - Cycle 0 (first cycle with `rst` low): RST.
  - Cycles 1..LINES: SWEEP, writing index c-1.
  - Cycle LINES+1: IDLE, with `busy` = 0 and `lk_ready` = 1 if there is no fill or `inv_all`.
- Lookup latency: accept in cycle N, `rsp_valid` in N+1. Throughput is 1 per cycle.
- Fill latency: the write commits at the edge ending the accept cycle.
- `inv_all` in IDLE cycle N: SWEEP in N+1..N+LINES, IDLE in N+LINES+1.
- Sweep counter never wraps: with LINES = 128, exit occurs at count 127.

## Test plan
- Reset for 3 cycles, then release:
  - `busy` is 1 for cycles 0..128.
  - Writes to indices 0..127, each with data 0.
  - `lk_ready` rises in cycle 129.
  - A lookup at idx 5 then returns `rsp_hit` = 0.
- Fill idx 0x12 tag 0x0ABCD, then lookups:
  - Lookup idx 0x12 tag 0x0ABCD in the next cycle: `rsp_valid` = 1, `rsp_hit` = 1 one cycle later.
  - Tag 0x0ABCE: hit = 0.
  - Idx 0x13: hit = 0.
- Same cycle `fill_valid` and `lk_valid`:
  - Fill is accepted and `lk_ready` = 0.
  - Lookup is accepted the next cycle and hits if it matches the fill.
- Back-to-back lookups on 4 consecutive cycles with alternating hit/miss: `rsp_valid` holds 4 cycles with hit pattern 1,0,1,0.
- `inv_all` one cycle after a lookup accept:
  - The pending response is still delivered.
  - `busy` stays high for 128 cycles.
  - A prior hit line then misses.
  - A second `inv_all` at sweep count 60 extends the sweep to 128 cycles from the restart.
- `rst` asserted at sweep count 40: outputs go to reset values immediately; after release the full 128-line sweep reruns.
